// File: rtl/fcfs_arbiter_if.sv
// Requester/completer handshake bundle between the crossbar and its arbiter.
// The arbiter takes the slave side; the crossbar or a bench drives the master side.
interface fcfs_arbiter_if #(
    parameter int NUM_RN = 3,
    parameter int NUM_CN = 3,
    parameter int SEL_W  = $clog2(NUM_CN + 1),
    parameter int IDX_W  = $clog2(NUM_RN)
);
    logic [NUM_RN-1:0] rn_valid;
    logic [NUM_CN-1:0] icn_psel;
    logic [NUM_RN-1:0] cn_ready;
    logic [SEL_W-1:0]  crossbar_sel;
    logic [IDX_W-1:0]  grant_id;
    logic              busy;

    modport master (
        output rn_valid, icn_psel,
        input  cn_ready, crossbar_sel, grant_id, busy
    );

    modport slave (
        input  rn_valid, icn_psel,
        output cn_ready, crossbar_sel, grant_id, busy
    );
endinterface

// File: rtl/fcfs_arbiter.sv
// Shared-completer arbiter: FCFS queue or round-robin grant, optional hold-limit
// preemption, and one-hot completer select decode for the crossbar mux.
module fcfs_arbiter #(
    parameter int NUM_RN     = 3,
    parameter int NUM_CN     = 3,
    parameter int MODE       = 0,
    parameter int HOLD_LIMIT = 0,
    parameter int SEL_W      = $clog2(NUM_CN + 1),
    parameter int IDX_W      = $clog2(NUM_RN)
) (
    input  logic          clk,
    input  logic          rst,
    fcfs_arbiter_if.slave bus
);

    localparam int HC_W = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_RN-1:0] cn_ready_q, cn_ready_d;
    logic              busy_q, busy_d;
    idx_t              grant_id_q, grant_id_d;
    idx_t              last_owner_q, last_owner_d;
    logic [NUM_RN-1:0] pending_q, pending_d;
    idx_t              queue_q [NUM_RN];
    idx_t              queue_d [NUM_RN];
    logic [NUM_RN-1:0] qvalid_q, qvalid_d;
    logic [HC_W-1:0]   hold_q, hold_d;

    idx_t              owner, cand;
    logic              owner_valid, cand_ok, grant, release_own, preempt, placed;
    logic [NUM_RN-1:0] live, arrivals, owner_mask;
    logic [HC_W-1:0]   hold_nxt;
    logic [SEL_W-1:0]  sel;
    logic              sel_hit, sel_multi;

    always_comb begin
        owner       = grant_id_q;
        owner_valid = bus.rn_valid[owner];
        owner_mask  = '0;
        owner_mask[owner] = busy_q;
        live        = pending_q & bus.rn_valid;
        arrivals    = bus.rn_valid & ~pending_q & ~owner_mask;
        placed      = 1'b0;

        // Withdrawn entries drop out; survivors bubble forward keeping their order.
        for (int i = 0; i < NUM_RN; i++) begin
            queue_d[i]  = queue_q[i];
            qvalid_d[i] = qvalid_q[i] && bus.rn_valid[queue_q[i]];
        end
        for (int p = 0; p < NUM_RN - 1; p++) begin
            for (int i = 0; i < NUM_RN - 1; i++) begin
                if (!qvalid_d[i] && qvalid_d[i+1]) begin
                    queue_d[i]    = queue_d[i+1];
                    qvalid_d[i]   = 1'b1;
                    qvalid_d[i+1] = 1'b0;
                end
            end
        end

        cand    = '0;
        cand_ok = 1'b0;
        if (MODE == 0) begin
            cand    = queue_d[0];
            cand_ok = qvalid_d[0];
        end else begin
            for (int k = 0; k < NUM_RN; k++) begin
                if (!cand_ok && live[k] && (idx_t'(k) > last_owner_q)) begin
                    cand    = idx_t'(k);
                    cand_ok = 1'b1;
                end
            end
            for (int k = 0; k < NUM_RN; k++) begin
                if (!cand_ok && live[k]) begin
                    cand    = idx_t'(k);
                    cand_ok = 1'b1;
                end
            end
        end

        grant     = !busy_q && cand_ok;
        pending_d = live;
        if (grant) begin
            pending_d[cand] = 1'b0;
            if (MODE == 0) begin
                for (int i = 0; i < NUM_RN - 1; i++) begin
                    queue_d[i]  = queue_d[i+1];
                    qvalid_d[i] = qvalid_d[i+1];
                end
                queue_d[NUM_RN-1]  = '0;
                qvalid_d[NUM_RN-1] = 1'b0;
            end
        end

        hold_nxt    = (hold_q == HC_W'(HOLD_LIMIT)) ? hold_q : hold_q + 1'b1;
        release_own = busy_q && !owner_valid;
        preempt     = (HOLD_LIMIT > 0) && busy_q && owner_valid &&
                      (hold_nxt == HC_W'(HOLD_LIMIT)) && (live != '0);

        for (int r = 0; r < NUM_RN; r++) begin
            if (arrivals[r]) begin
                pending_d[r] = 1'b1;
                if (MODE == 0) begin
                    placed = 1'b0;
                    for (int j = 0; j < NUM_RN; j++) begin
                        if (!placed && !qvalid_d[j]) begin
                            queue_d[j]  = idx_t'(r);
                            qvalid_d[j] = 1'b1;
                            placed      = 1'b1;
                        end
                    end
                end
            end
        end
        // A preempted owner goes behind everyone, including this edge's arrivals.
        if (preempt) begin
            pending_d[owner] = 1'b1;
            if (MODE == 0) begin
                placed = 1'b0;
                for (int j = 0; j < NUM_RN; j++) begin
                    if (!placed && !qvalid_d[j]) begin
                        queue_d[j]  = owner;
                        qvalid_d[j] = 1'b1;
                        placed      = 1'b1;
                    end
                end
            end
        end

        cn_ready_d   = cn_ready_q;
        busy_d       = busy_q;
        grant_id_d   = grant_id_q;
        last_owner_d = last_owner_q;
        hold_d       = hold_q;
        if (grant) begin
            cn_ready_d       = '0;
            cn_ready_d[cand] = 1'b1;
            busy_d           = 1'b1;
            grant_id_d       = cand;
            hold_d           = '0;
        end else if (release_own || preempt) begin
            cn_ready_d   = '0;
            busy_d       = 1'b0;
            last_owner_d = owner;
            hold_d       = '0;
        end else if (busy_q) begin
            hold_d = hold_nxt;
        end
    end

    // Completer select: exactly one bit set maps to index+1, anything else to 0.
    always_comb begin
        sel       = '0;
        sel_hit   = 1'b0;
        sel_multi = 1'b0;
        for (int i = 0; i < NUM_CN; i++) begin
            if (bus.icn_psel[i]) begin
                if (sel_hit) begin
                    sel_multi = 1'b1;
                end else begin
                    sel_hit = 1'b1;
                    sel     = SEL_W'(i + 1);
                end
            end
        end
        if (sel_multi) begin
            sel = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cn_ready_q   <= '0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            last_owner_q <= idx_t'(NUM_RN - 1);
            pending_q    <= '0;
            qvalid_q     <= '0;
            hold_q       <= '0;
            for (int i = 0; i < NUM_RN; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            cn_ready_q   <= cn_ready_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            last_owner_q <= last_owner_d;
            pending_q    <= pending_d;
            qvalid_q     <= qvalid_d;
            hold_q       <= hold_d;
            for (int i = 0; i < NUM_RN; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end

    assign bus.cn_ready     = cn_ready_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.crossbar_sel = sel;

endmodule

// File: tb/tb_fcfs_arbiter.sv
// Directed bench for fcfs_arbiter: FCFS, round-robin and hold-limit instances
// share clock and reset; each section drives one instance and idles the others.
module tb_fcfs_arbiter;

    localparam int F = 0;
    localparam int R = 1;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fcfs_arbiter_if #(.NUM_RN(3), .NUM_CN(3)) f_if ();
    fcfs_arbiter_if #(.NUM_RN(3), .NUM_CN(3)) r_if ();
    fcfs_arbiter_if #(.NUM_RN(3), .NUM_CN(3)) p_if ();

    fcfs_arbiter #(.NUM_RN(3), .NUM_CN(3), .MODE(0), .HOLD_LIMIT(0)) u_fcfs (
        .clk(clk), .rst(rst), .bus(f_if));
    fcfs_arbiter #(.NUM_RN(3), .NUM_CN(3), .MODE(1), .HOLD_LIMIT(0)) u_rr (
        .clk(clk), .rst(rst), .bus(r_if));
    fcfs_arbiter #(.NUM_RN(3), .NUM_CN(3), .MODE(0), .HOLD_LIMIT(4)) u_pre (
        .clk(clk), .rst(rst), .bus(p_if));

    typedef struct {
        logic [2:0] valid;
        logic [2:0] psel;
        logic [2:0] rdy;
        logic       busy;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl [18];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [1:0] oh2idx(input logic [2:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

    task automatic drive(input int dut, input logic [2:0] v);
        case (dut)
            F:       f_if.rn_valid = v;
            R:       r_if.rn_valid = v;
            default: p_if.rn_valid = v;
        endcase
    endtask

    task automatic check(input string name, input int dut,
                         input logic [2:0] er, input logic eb);
        logic [2:0] rdy;
        logic       bsy;
        logic [1:0] gid;
        case (dut)
            F:       begin rdy = f_if.cn_ready; bsy = f_if.busy; gid = f_if.grant_id; end
            R:       begin rdy = r_if.cn_ready; bsy = r_if.busy; gid = r_if.grant_id; end
            default: begin rdy = p_if.cn_ready; bsy = p_if.busy; gid = p_if.grant_id; end
        endcase
        n_vec++;
        if (rdy !== er || bsy !== eb || (eb && gid !== oh2idx(er))) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t: cn_ready=%b busy=%b grant_id=%0d, want cn_ready=%b busy=%b grant_id=%0d",
                     name, dut, $time, rdy, bsy, gid, er, eb, oh2idx(er));
        end
    endtask

    task automatic step(input string name, input int dut, input logic [2:0] v,
                        input logic [2:0] er, input logic eb);
        drive(dut, v);
        @(posedge clk);
        #1;
        check(name, dut, er, eb);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(F, 3'b000);
        drive(R, 3'b000);
        drive(P, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ($countones(f_if.cn_ready) > 1 || $countones(r_if.cn_ready) > 1 ||
                     $countones(p_if.cn_ready) > 1)) begin
            n_err++;
            $display("FAIL onehot t=%0t: cn_ready f=%b r=%b p=%b, want at most one bit",
                     $time, f_if.cn_ready, r_if.cn_ready, p_if.cn_ready);
        end
    end

    initial begin
        logic [2:0] oh;
        logic [1:0] s;

        // rn_valid | icn_psel | cn_ready | busy | crossbar_sel
        tbl[0]  = '{3'b000, 3'b001, 3'b000, 1'b0, 2'd1};
        tbl[1]  = '{3'b100, 3'b010, 3'b000, 1'b0, 2'd2};
        tbl[2]  = '{3'b101, 3'b100, 3'b100, 1'b1, 2'd3};
        tbl[3]  = '{3'b111, 3'b000, 3'b100, 1'b1, 2'd0};
        tbl[4]  = '{3'b111, 3'b011, 3'b100, 1'b1, 2'd0};
        tbl[5]  = '{3'b111, 3'b110, 3'b100, 1'b1, 2'd0};
        tbl[6]  = '{3'b011, 3'b111, 3'b000, 1'b0, 2'd0};
        tbl[7]  = '{3'b011, 3'b101, 3'b001, 1'b1, 2'd0};
        tbl[8]  = '{3'b011, 3'b001, 3'b001, 1'b1, 2'd1};
        tbl[9]  = '{3'b011, 3'b010, 3'b001, 1'b1, 2'd2};
        tbl[10] = '{3'b011, 3'b100, 3'b001, 1'b1, 2'd3};
        tbl[11] = '{3'b010, 3'b000, 3'b000, 1'b0, 2'd0};
        tbl[12] = '{3'b010, 3'b011, 3'b010, 1'b1, 2'd0};
        tbl[13] = '{3'b010, 3'b001, 3'b010, 1'b1, 2'd1};
        tbl[14] = '{3'b010, 3'b100, 3'b010, 1'b1, 2'd3};
        tbl[15] = '{3'b010, 3'b010, 3'b010, 1'b1, 2'd2};
        tbl[16] = '{3'b000, 3'b110, 3'b000, 1'b0, 2'd0};
        tbl[17] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd0};

        f_if.rn_valid = '0; f_if.icn_psel = '0;
        r_if.rn_valid = '0; r_if.icn_psel = '0;
        p_if.rn_valid = '0; p_if.icn_psel = '0;

        // Reset held two edges with every requester asserting.
        rst = 1'b1;
        drive(F, 3'b111); drive(R, 3'b111); drive(P, 3'b111);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("reset_hold", F, 3'b000, 1'b0);
            check("reset_hold", R, 3'b000, 1'b0);
            check("reset_hold", P, 3'b000, 1'b0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_push", F, 3'b000, 1'b0);
        check("post_reset_push", R, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_grant", F, 3'b001, 1'b1);
        check("post_reset_grant", R, 3'b001, 1'b1);
        check("post_reset_grant", P, 3'b001, 1'b1);
        drive(F, 3'b000); drive(R, 3'b000); drive(P, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_idle", F, 3'b000, 1'b0);

        // FCFS arrival order 2, 0, 1 with crossbar select decode riding along.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            f_if.icn_psel = tbl[i].psel;
            #1;
            n_vec++;
            s = f_if.crossbar_sel;
            if (s !== tbl[i].sel) begin
                n_err++;
                $display("FAIL crossbar_sel[%0d]: psel=%b got %0d want %0d",
                         i, tbl[i].psel, s, tbl[i].sel);
            end
            step($sformatf("fcfs_vec[%0d]", i), F, tbl[i].valid, tbl[i].rdy, tbl[i].busy);
        end

        // Round-robin: each owner drops one cycle after its grant, then re-raises.
        do_reset();
        step("rr_push", R, 3'b111, 3'b000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            oh = 3'b001 << (i % 3);
            step($sformatf("rr_grant[%0d]", i), R, 3'b111, oh, 1'b1);
            step($sformatf("rr_release[%0d]", i), R, 3'b111 & ~oh, 3'b000, 1'b0);
        end

        // Withdrawal: RN1 owns, queue [2,0], RN2 blips low for one cycle.
        do_reset();
        step("wd_push1",    F, 3'b010, 3'b000, 1'b0);
        step("wd_grant1",   F, 3'b110, 3'b010, 1'b1);
        step("wd_push0",    F, 3'b111, 3'b010, 1'b1);
        step("wd_drop2",    F, 3'b011, 3'b010, 1'b1);
        step("wd_repush2",  F, 3'b111, 3'b010, 1'b1);
        step("wd_release1", F, 3'b101, 3'b000, 1'b0);
        step("wd_grant0",   F, 3'b101, 3'b001, 1'b1);
        step("wd_release0", F, 3'b100, 3'b000, 1'b0);
        step("wd_grant2",   F, 3'b100, 3'b100, 1'b1);
        step("wd_release2", F, 3'b000, 3'b000, 1'b0);
        step("wd_idle",     F, 3'b000, 3'b000, 1'b0);

        // Hold limit 4: owners preempted in turn while the other waits.
        do_reset();
        step("pre_push0",     P, 3'b001, 3'b000, 1'b0);
        step("pre_grant0",    P, 3'b001, 3'b001, 1'b1);
        for (int i = 0; i < 3; i++)
            step($sformatf("pre_hold0[%0d]", i), P, 3'b011, 3'b001, 1'b1);
        step("pre_preempt0",  P, 3'b011, 3'b000, 1'b0);
        step("pre_grant1",    P, 3'b011, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++)
            step($sformatf("pre_hold1[%0d]", i), P, 3'b011, 3'b010, 1'b1);
        step("pre_preempt1",  P, 3'b011, 3'b000, 1'b0);
        step("pre_regrant0",  P, 3'b011, 3'b001, 1'b1);
        for (int i = 0; i < 8; i++)
            step($sformatf("pre_saturate[%0d]", i), P, 3'b001, 3'b001, 1'b1);

        // Reset in the middle of a grant wins over the held request.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", P, 3'b000, 1'b0);
        rst = 1'b0;
        step("mid_reset_push",  P, 3'b001, 3'b000, 1'b0);
        step("mid_reset_grant", P, 3'b001, 3'b001, 1'b1);
        step("mid_reset_drop",  P, 3'b000, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
